cmp_hold_detector: RTL

- Downstream consumer of the 4-bit magnitude comparator's one-hot result flags (greater, equal, less).
- Qualifies the "A > B" condition with a hold/debounce state machine: a condition change is accepted only after HOLD consecutive valid samples agree.
- Emits single-cycle rise/fall pulses and a saturating count of qualified rises.
- Flags any malformed comparator result.

---
 rtl/cmp_hold_detector.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/cmp_hold_detector.sv
// cmp_hold_detector: qualifies the comparator's "A > B" flag with a hold/debounce
// state machine, emits rise/fall pulses, counts qualified rises and flags
// malformed comparator results.
module cmp_hold_detector #(
    parameter int HOLD  = 3,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             greater,
    input  logic             equal,
    input  logic             less,
    input  logic             clear,
    output logic [1:0]       state,
    output logic             qual_hi,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic [CNT_W-1:0] event_cnt,
    output logic             err
);

    typedef enum logic [1:0] {
        LOW     = 2'b00,
        PEND_HI = 2'b01,
        HIGH    = 2'b10,
        PEND_LO = 2'b11
    } state_t;

    localparam logic [8:0]       HOLD_W  = 9'(HOLD);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t     cur_state;
    state_t     nxt_state;
    logic [7:0] run;
    logic [7:0] nxt_run;
    logic [8:0] run_inc;
    logic       nxt_rise;
    logic       nxt_fall;
    logic       sample_hi;
    logic       sample_lo;
    logic       illegal;

    // A sample is "hi" only for a clean greater flag, "lo" for a clean equal or less flag
    assign sample_hi = in_valid & greater & ~equal & ~less;
    assign sample_lo = in_valid & (equal | less) & ~greater & ~(equal & less);
    assign illegal   = in_valid & ~sample_hi & ~sample_lo;
    assign run_inc   = {1'b0, run} + 9'd1;
    assign state     = cur_state;

    // Next-state logic: a change of qualified level needs HOLD agreeing valid samples
    always_comb begin
        nxt_state = cur_state;
        nxt_run   = run;
        nxt_rise  = 1'b0;
        nxt_fall  = 1'b0;
        case (cur_state)
            LOW: begin
                if (sample_hi) begin
                    if (HOLD == 1) begin
                        nxt_state = HIGH;
                        nxt_rise  = 1'b1;
                        nxt_run   = 8'd0;
                    end else begin
                        nxt_state = PEND_HI;
                        nxt_run   = 8'd1;
                    end
                end
            end
            PEND_HI: begin
                if (sample_hi) begin
                    if (run_inc == HOLD_W) begin
                        nxt_state = HIGH;
                        nxt_rise  = 1'b1;
                        nxt_run   = 8'd0;
                    end else begin
                        nxt_run = run_inc[7:0];
                    end
                end else if (sample_lo) begin
                    nxt_state = LOW;
                    nxt_run   = 8'd0;
                end
            end
            HIGH: begin
                if (sample_lo) begin
                    if (HOLD == 1) begin
                        nxt_state = LOW;
                        nxt_fall  = 1'b1;
                        nxt_run   = 8'd0;
                    end else begin
                        nxt_state = PEND_LO;
                        nxt_run   = 8'd1;
                    end
                end
            end
            PEND_LO: begin
                if (sample_lo) begin
                    if (run_inc == HOLD_W) begin
                        nxt_state = LOW;
                        nxt_fall  = 1'b1;
                        nxt_run   = 8'd0;
                    end else begin
                        nxt_run = run_inc[7:0];
                    end
                end else if (sample_hi) begin
                    nxt_state = HIGH;
                    nxt_run   = 8'd0;
                end
            end
            default: begin
                nxt_state = LOW;
                nxt_run   = 8'd0;
            end
        endcase
    end

    // State, run counter and all registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_state  <= LOW;
            run        <= 8'd0;
            qual_hi    <= 1'b0;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
        end else begin
            cur_state  <= nxt_state;
            run        <= nxt_run;
            qual_hi    <= (nxt_state == HIGH) || (nxt_state == PEND_LO);
            rise_pulse <= nxt_rise;
            fall_pulse <= nxt_fall;
        end
    end

    // Saturating rise counter and sticky error; clear takes priority over both
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            event_cnt <= '0;
            err       <= 1'b0;
        end else begin
            if (clear) begin
                event_cnt <= '0;
            end else if (nxt_rise && (event_cnt != CNT_MAX)) begin
                event_cnt <= event_cnt + 1'b1;
            end
            if (clear) begin
                err <= 1'b0;
            end else if (illegal) begin
                err <= 1'b1;
            end
        end
    end

endmodule
